regfile_rd_scoreboard: RTL and testbench

//  Architectural GPR file (32 x XLEN) plus per-register pending-write scoreboard.

---
 rtl/regfile_rd_scoreboard_pkg.sv | 16 +
 rtl/regfile_rd_scoreboard_sb_counter.sv | 54 +++++
 rtl/regfile_rd_scoreboard.sv | 87 ++++++++
 tb/tb_regfile_rd_scoreboard.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_rd_scoreboard_pkg.sv
// Shared widths and defaults for the GPR file and its pending-write scoreboard.
package regfile_rd_scoreboard_pkg;

    localparam int unsigned XLEN_DEF   = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREG_DEF   = 32;
    localparam int unsigned PEND_W_DEF = 2;

    typedef enum logic [1:0] {
        SB_HOLD = 2'd0,
        SB_INC  = 2'd1,
        SB_DEC  = 2'd2,
        SB_CLR  = 2'd3
    } sb_op_e;

endpackage

// File: rtl/regfile_rd_scoreboard_sb_counter.sv
// Per-register pending-writer counter: saturating up/down with synchronous clear.
module sb_counter
    import regfile_rd_scoreboard_pkg::*;
#(
    parameter int unsigned PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic              clr_i,
    output logic [PEND_W-1:0] cnt_o
);

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;
    logic              dec_eff;
    sb_op_e            op;

    // A retire seen while already at zero is ignored rather than wrapping.
    assign dec_eff = dec_i && (cnt_q != '0);

    always_comb begin
        op = SB_HOLD;
        if (clr_i) begin
            op = SB_CLR;
        end else if (inc_i && !dec_eff) begin
            op = SB_INC;
        end else if (dec_eff && !inc_i) begin
            op = SB_DEC;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case (op)
            SB_CLR:  cnt_d = '0;
            SB_INC:  if (cnt_q != '1) cnt_d = cnt_q + PEND_W'(1);
            SB_DEC:  cnt_d = cnt_q - PEND_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_rd_scoreboard.sv
// GPR file with same-cycle writeback bypass and per-register pending-write scoreboard.
module regfile_rd_scoreboard
    import regfile_rd_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned PEND_W = PEND_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_ena,
    input  logic [REG_ADDR_W-1:0] w_addr,
    input  logic [XLEN-1:0]       w_data,
    input  logic                  r1_ena,
    input  logic [REG_ADDR_W-1:0] r1_addr,
    output logic [XLEN-1:0]       r1_data,
    input  logic                  r2_ena,
    input  logic [REG_ADDR_W-1:0] r2_addr,
    output logic [XLEN-1:0]       r2_data,
    input  logic                  issue_fire,
    input  logic                  issue_rd_wen,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  flush,
    output logic                  stall
);

    logic [XLEN-1:0]   gpr_q [NREG];
    logic [PEND_W-1:0] pend  [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr_q <= '{default: '0};
        end else if (w_ena && (w_addr != '0)) begin
            gpr_q[w_addr] <= w_data;
        end
    end

    assign pend[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_sb
        logic inc;
        logic dec;
        assign inc = issue_fire && issue_rd_wen && (issue_rd == REG_ADDR_W'(i)) && !flush;
        assign dec = w_ena && (w_addr == REG_ADDR_W'(i));
        sb_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (inc),
            .dec_i (dec),
            .clr_i (flush),
            .cnt_o (pend[i])
        );
    end

    function automatic logic [XLEN-1:0] read_port(input logic                  ena,
                                                  input logic [REG_ADDR_W-1:0] addr);
        if (!ena || addr == '0) begin
            return '0;
        end else if (w_ena && w_addr == addr) begin
            return w_data;
        end
        return gpr_q[addr];
    endfunction

    // The last outstanding writer retiring this cycle is covered by the bypass.
    function automatic logic busy(input logic [REG_ADDR_W-1:0] addr);
        return (pend[addr] != '0) &&
               !(w_ena && (w_addr == addr) && (pend[addr] == PEND_W'(1)));
    endfunction

    always_comb begin
        r1_data = read_port(r1_ena, r1_addr);
        r2_data = read_port(r2_ena, r2_addr);
    end

    always_comb begin
        stall = 1'b0;
        if (r1_ena && (r1_addr != '0) && busy(r1_addr)) stall = 1'b1;
        if (r2_ena && (r2_addr != '0) && busy(r2_addr)) stall = 1'b1;
        if (issue_rd_wen && (issue_rd != '0) && (pend[issue_rd] == '1)) stall = 1'b1;
        if (flush) stall = 1'b0;
    end

    a_no_issue_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue_fire && stall));

endmodule

// File: tb/tb_regfile_rd_scoreboard.sv
// Directed-vector bench: stimulus pushes expected responses, a negedge monitor checks them.
module tb_regfile_rd_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        w_ena;
    logic [4:0]  w_addr;
    logic [63:0] w_data;
    logic        r1_ena;
    logic [4:0]  r1_addr;
    logic [63:0] r1_data;
    logic        r2_ena;
    logic [4:0]  r2_addr;
    logic [63:0] r2_data;
    logic        issue_fire;
    logic        issue_rd_wen;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        stall;

    regfile_rd_scoreboard #(.XLEN(64), .NREG(32), .PEND_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_ena        (w_ena),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .r1_ena       (r1_ena),
        .r1_addr      (r1_addr),
        .r1_data      (r1_data),
        .r2_ena       (r2_ena),
        .r2_addr      (r2_addr),
        .r2_data      (r2_data),
        .issue_fire   (issue_fire),
        .issue_rd_wen (issue_rd_wen),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] M_R1 = 3'b001;
    localparam logic [2:0] M_R2 = 3'b010;
    localparam logic [2:0] M_ST = 3'b100;

    typedef struct {
        string       name;
        logic [2:0]  mask;
        logic [63:0] r1;
        logic [63:0] r2;
        logic        st;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;
    bit   stim_done;

    task automatic expect_out(input string name, input logic [2:0] mask,
                              input logic [63:0] r1, input logic [63:0] r2, input logic st);
        exp_t e;
        e.name = name; e.mask = mask; e.r1 = r1; e.r2 = r2; e.st = st;
        q.push_back(e);
    endtask

    task automatic idle();
        w_ena = 0; w_addr = 0; w_data = '0;
        r1_ena = 0; r1_addr = 0; r2_ena = 0; r2_addr = 0;
        issue_fire = 0; issue_rd_wen = 0; issue_rd = 0; flush = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_fire = 1; issue_rd_wen = 1; issue_rd = rd;
    endtask

    task automatic wb(input logic [4:0] a, input logic [63:0] d);
        w_ena = 1; w_addr = a; w_data = d;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.mask[0]) begin
                n_cmp++;
                if (r1_data !== e.r1) begin
                    n_bad++;
                    $display("FAIL %s r1_data got=%h exp=%h", e.name, r1_data, e.r1);
                end
            end
            if (e.mask[1]) begin
                n_cmp++;
                if (r2_data !== e.r2) begin
                    n_bad++;
                    $display("FAIL %s r2_data got=%h exp=%h", e.name, r2_data, e.r2);
                end
            end
            if (e.mask[2]) begin
                n_cmp++;
                if (stall !== e.st) begin
                    n_bad++;
                    $display("FAIL %s stall got=%b exp=%b", e.name, stall, e.st);
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; stim_done = 0;
        idle();
        rst_n = 0;
        #1;
        r1_ena = 1; r1_addr = 5;
        expect_out("reset_state", M_R1 | M_ST, 64'h0, 64'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1; idle(); rst_n = 1;

        // mid-run reset
        wb(5, 64'hDEAD); r1_ena = 1; r1_addr = 5;
        expect_out("wr_x5_bypass", M_R1 | M_ST, 64'hDEAD, 64'h0, 1'b0);
        next_cycle(); r1_ena = 1; r1_addr = 5; issue(6);
        expect_out("rd_x5_gpr", M_R1 | M_ST, 64'hDEAD, 64'h0, 1'b0);
        next_cycle(); rst_n = 0; r1_ena = 1; r1_addr = 5; r2_ena = 1; r2_addr = 6;
        expect_out("async_reset", M_R1 | M_R2 | M_ST, 64'h0, 64'h0, 1'b0);

        // bypass
        next_cycle(); rst_n = 1; wb(7, 64'h1234); r1_ena = 1; r1_addr = 7; r2_ena = 1; r2_addr = 5;
        expect_out("bypass_x7", M_R1 | M_R2 | M_ST, 64'h1234, 64'h0, 1'b0);
        next_cycle(); r1_ena = 1; r1_addr = 7;
        expect_out("gpr_x7", M_R1 | M_ST, 64'h1234, 64'h0, 1'b0);

        // x0
        next_cycle(); issue(0); wb(0, 64'hFF); r1_ena = 1; r1_addr = 0; r2_ena = 1; r2_addr = 0;
        expect_out("x0_write_bypass", M_R1 | M_R2 | M_ST, 64'h0, 64'h0, 1'b0);
        next_cycle(); r1_ena = 1; r1_addr = 0; issue_rd_wen = 1; issue_rd = 0;
        expect_out("x0_after", M_R1 | M_ST, 64'h0, 64'h0, 1'b0);

        // RAW
        next_cycle(); issue(3);
        expect_out("raw_issue", M_ST, 64'h0, 64'h0, 1'b0);
        next_cycle(); r2_ena = 1; r2_addr = 3;
        expect_out("raw_stall1", M_R2 | M_ST, 64'h0, 64'h0, 1'b1);
        next_cycle(); r2_ena = 1; r2_addr = 3;
        expect_out("raw_stall2", M_ST, 64'h0, 64'h0, 1'b1);
        next_cycle(); r2_ena = 1; r2_addr = 3; wb(3, 64'hABCD);
        expect_out("raw_wb", M_R2 | M_ST, 64'h0, 64'hABCD, 1'b0);
        next_cycle(); r2_ena = 1; r2_addr = 3;
        expect_out("raw_after", M_R2 | M_ST, 64'h0, 64'hABCD, 1'b0);

        // saturation
        for (int k = 0; k < 3; k++) begin
            next_cycle(); issue(9);
            expect_out("sat_issue", M_ST, 64'h0, 64'h0, 1'b0);
        end
        next_cycle(); issue_rd_wen = 1; issue_rd = 9;
        expect_out("sat_full", M_ST, 64'h0, 64'h0, 1'b1);
        next_cycle(); issue_rd_wen = 1; issue_rd = 9; wb(9, 64'h99);
        expect_out("sat_wb_cycle", M_ST, 64'h0, 64'h0, 1'b1);
        next_cycle(); issue_rd_wen = 1; issue_rd = 9;
        expect_out("sat_pend2", M_ST, 64'h0, 64'h0, 1'b0);
        next_cycle(); r1_ena = 1; r1_addr = 9;
        expect_out("sat_busy", M_R1 | M_ST, 64'h99, 64'h0, 1'b1);
        next_cycle(); r1_ena = 1; r1_addr = 9; flush = 1;
        expect_out("flush_masks", M_ST, 64'h0, 64'h0, 1'b0);
        next_cycle(); r1_ena = 1; r1_addr = 9;
        expect_out("flush_clr9", M_R1 | M_ST, 64'h99, 64'h0, 1'b0);

        // flush with issue and WB in the same cycle
        next_cycle(); issue(4);
        next_cycle(); issue(4);
        next_cycle(); r1_ena = 1; r1_addr = 4;
        expect_out("fl_pend2", M_ST, 64'h0, 64'h0, 1'b1);
        next_cycle(); flush = 1; issue(4); wb(4, 64'h4444); r1_ena = 1; r1_addr = 4;
        expect_out("fl_cycle", M_R1 | M_ST, 64'h4444, 64'h0, 1'b0);
        next_cycle(); r1_ena = 1; r1_addr = 4;
        expect_out("fl_after", M_R1 | M_ST, 64'h4444, 64'h0, 1'b0);

        // last writer retiring, then a WB with nothing pending
        next_cycle(); issue(10);
        next_cycle(); wb(10, 64'h10); r1_ena = 1; r1_addr = 10;
        expect_out("last_retire", M_R1 | M_ST, 64'h10, 64'h0, 1'b0);
        next_cycle(); wb(10, 64'h11);
        next_cycle(); issue(10); r1_ena = 1; r1_addr = 10;
        expect_out("no_underflow0", M_R1 | M_ST, 64'h11, 64'h0, 1'b0);
        next_cycle(); r1_ena = 1; r1_addr = 10;
        expect_out("no_underflow1", M_ST, 64'h0, 64'h0, 1'b1);
        next_cycle();
        stim_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        #1;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout stim_done=%0b exp=1", stim_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
